// File: rtl/armv8_pipe_pkg.sv
// Shared widths, control-word bit layout and operand-select helper for the ARMv8 pipeline.
// Defining ID_EX_XZR_EN makes index 31 the zero register (XZR) instead of an ordinary register.
package armv8_pipe_pkg;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 5;
    localparam int CTRL_W = 10;

    // id_ctrl = {RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, Branch, ALUOp[3:0]}
    localparam int CTRL_REGWRITE  = 9;
    localparam int CTRL_MEMREAD   = 8;
    localparam int CTRL_MEMWRITE  = 7;
    localparam int CTRL_MEMTOREG  = 6;
    localparam int CTRL_ALUSRC    = 5;
    localparam int CTRL_BRANCH    = 4;
    localparam int CTRL_ALUOP_MSB = 3;
    localparam int CTRL_ALUOP_LSB = 0;

    localparam logic [ADDR_W-1:0] XZR_IDX = ADDR_W'(31);

    // The RF write lands on the same edge as capture, so a matching writeback is forwarded here.
    function automatic logic [DATA_W-1:0] sel_operand(
        input logic [ADDR_W-1:0] src,
        input logic [DATA_W-1:0] rf_data,
        input logic              wb_en,
        input logic [ADDR_W-1:0] wb_rd,
        input logic [DATA_W-1:0] wb_data
    );
        logic [DATA_W-1:0] res;
        res = (wb_en && (wb_rd == src)) ? wb_data : rf_data;
`ifdef ID_EX_XZR_EN
        if (src == XZR_IDX) res = '0;
`endif
        return res;
    endfunction

endpackage

// File: rtl/load_use_hazard.sv
// Combinational load-use hazard detect between the EX slot and the instruction in decode.
// With ID_EX_XZR_EN defined, a load targeting index 31 never raises a hazard.
module load_use_hazard
    import armv8_pipe_pkg::*;
(
    input  logic              ex_valid_i,
    input  logic              ex_memread_i,
    input  logic [ADDR_W-1:0] ex_rd_i,
    input  logic              id_valid_i,
    input  logic [ADDR_W-1:0] id_rn_i,
    input  logic [ADDR_W-1:0] id_rm_i,
    input  logic              id_use_rn_i,
    input  logic              id_use_rm_i,
    input  logic              flush_i,
    output logic              hazard_o
);

    logic rd_ok;
    logic src_match;

`ifdef ID_EX_XZR_EN
    assign rd_ok = (ex_rd_i != XZR_IDX);
`else
    assign rd_ok = 1'b1;
`endif

    assign src_match = (id_use_rn_i && (ex_rd_i == id_rn_i)) ||
                       (id_use_rm_i && (ex_rd_i == id_rm_i));

    assign hazard_o = ex_valid_i && ex_memread_i && rd_ok && src_match &&
                      id_valid_i && !flush_i;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with writeback bypass, load-use bubble insertion and flush/hold.
// ID_EX_XZR_EN (optional) treats register index 31 as XZR for operands and hazards.
module id_ex_stage
    import armv8_pipe_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              id_valid_i,
    input  logic [ADDR_W-1:0] id_rn_i,
    input  logic [ADDR_W-1:0] id_rm_i,
    input  logic [ADDR_W-1:0] id_rd_i,
    input  logic              id_use_rn_i,
    input  logic              id_use_rm_i,
    input  logic [DATA_W-1:0] id_rd1_i,
    input  logic [DATA_W-1:0] id_rd2_i,
    input  logic [DATA_W-1:0] id_imm_i,
    input  logic [CTRL_W-1:0] id_ctrl_i,
    input  logic              wb_regwrite_i,
    input  logic [ADDR_W-1:0] wb_rd_i,
    input  logic [DATA_W-1:0] wb_data_i,
    input  logic              flush_i,
    input  logic              hold_i,
    output logic              ex_valid_o,
    output logic [DATA_W-1:0] ex_op1_o,
    output logic [DATA_W-1:0] ex_op2_o,
    output logic [DATA_W-1:0] ex_imm_o,
    output logic [ADDR_W-1:0] ex_rn_o,
    output logic [ADDR_W-1:0] ex_rm_o,
    output logic [ADDR_W-1:0] ex_rd_o,
    output logic [CTRL_W-1:0] ex_ctrl_o,
    output logic              stall_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] op1_q, op1_d, op2_q, op2_d, imm_q, imm_d;
    logic [ADDR_W-1:0] rn_q, rn_d, rm_q, rm_d, rd_q, rd_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              hazard;

    load_use_hazard u_hazard (
        .ex_valid_i   (valid_q),
        .ex_memread_i (ctrl_q[CTRL_MEMREAD]),
        .ex_rd_i      (rd_q),
        .id_valid_i   (id_valid_i),
        .id_rn_i      (id_rn_i),
        .id_rm_i      (id_rm_i),
        .id_use_rn_i  (id_use_rn_i),
        .id_use_rm_i  (id_use_rm_i),
        .flush_i      (flush_i),
        .hazard_o     (hazard)
    );

    // Held in reset, upstream must not see a freeze request even if hold is asserted.
    assign stall_o = rst_n_i && (hold_i || hazard);

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        imm_d   = imm_q;
        rn_d    = rn_q;
        rm_d    = rm_q;
        rd_d    = rd_q;
        if (flush_i) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else if (hold_i) begin
            valid_d = valid_q;
        end else if (hazard) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else begin
            valid_d = id_valid_i;
            ctrl_d  = id_valid_i ? id_ctrl_i : '0;
            op1_d   = sel_operand(id_rn_i, id_rd1_i, wb_regwrite_i, wb_rd_i, wb_data_i);
            op2_d   = sel_operand(id_rm_i, id_rd2_i, wb_regwrite_i, wb_rd_i, wb_data_i);
            imm_d   = id_imm_i;
            rn_d    = id_rn_i;
            rm_d    = id_rm_i;
            rd_d    = id_rd_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            imm_q   <= '0;
            rn_q    <= '0;
            rm_q    <= '0;
            rd_q    <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            imm_q   <= imm_d;
            rn_q    <= rn_d;
            rm_q    <= rm_d;
            rd_q    <= rd_d;
        end
    end

    assign ex_valid_o = valid_q;
    assign ex_ctrl_o  = ctrl_q;
    assign ex_op1_o   = op1_q;
    assign ex_op2_o   = op2_q;
    assign ex_imm_o   = imm_q;
    assign ex_rn_o    = rn_q;
    assign ex_rm_o    = rm_q;
    assign ex_rd_o    = rd_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; register-31 checks follow ID_EX_XZR_EN.
module tb_id_ex_stage;
    import armv8_pipe_pkg::*;

    localparam logic [CTRL_W-1:0] C_LDUR = 10'h360;  // RegWrite MemRead MemToReg ALUSrc
    localparam logic [CTRL_W-1:0] C_ADD  = 10'h202;  // RegWrite, ALUOp=2
    localparam logic [CTRL_W-1:0] C_SUB  = 10'h206;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              id_valid, id_use_rn, id_use_rm;
    logic [ADDR_W-1:0] id_rn, id_rm, id_rd, wb_rd;
    logic [DATA_W-1:0] id_rd1, id_rd2, id_imm, wb_data;
    logic [CTRL_W-1:0] id_ctrl;
    logic              wb_regwrite, flush, hold;
    logic              ex_valid, stall;
    logic [DATA_W-1:0] ex_op1, ex_op2, ex_imm;
    logic [ADDR_W-1:0] ex_rn, ex_rm, ex_rd;
    logic [CTRL_W-1:0] ex_ctrl;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .id_valid_i(id_valid), .id_rn_i(id_rn), .id_rm_i(id_rm), .id_rd_i(id_rd),
        .id_use_rn_i(id_use_rn), .id_use_rm_i(id_use_rm),
        .id_rd1_i(id_rd1), .id_rd2_i(id_rd2), .id_imm_i(id_imm), .id_ctrl_i(id_ctrl),
        .wb_regwrite_i(wb_regwrite), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
        .flush_i(flush), .hold_i(hold),
        .ex_valid_o(ex_valid), .ex_op1_o(ex_op1), .ex_op2_o(ex_op2), .ex_imm_o(ex_imm),
        .ex_rn_o(ex_rn), .ex_rm_o(ex_rm), .ex_rd_o(ex_rd), .ex_ctrl_o(ex_ctrl),
        .stall_o(stall)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_rn = 0; id_rm = 0; id_rd = 0; id_use_rn = 0; id_use_rm = 0;
        id_rd1 = 0; id_rd2 = 0; id_imm = 0; id_ctrl = 0;
        wb_regwrite = 0; wb_rd = 0; wb_data = 0; flush = 0; hold = 0;
    endtask

    task automatic issue(input logic [ADDR_W-1:0] rn, input logic [ADDR_W-1:0] rm,
                         input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] d1,
                         input logic [DATA_W-1:0] d2, input logic [CTRL_W-1:0] ctrl);
        id_valid = 1; id_rn = rn; id_rm = rm; id_rd = rd; id_use_rn = 1; id_use_rm = 1;
        id_rd1 = d1; id_rd2 = d2; id_imm = 64'h0; id_ctrl = ctrl;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        issue(5'd1, 5'd2, 5'd4, 64'h1234, 64'h5678, C_ADD);
        id_imm = 64'hFFFF_FFFF_FFFF_FFF0;
        step(); step();
        n_vec++;
        if (ex_valid !== 1'b0 || ex_op1 !== '0 || ex_op2 !== '0 || ex_ctrl !== '0 ||
            ex_imm !== '0 || ex_rd !== '0 || stall !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: valid=%b op1=%h ctrl=%h stall=%b, required all zero",
                     ex_valid, ex_op1, ex_ctrl, stall);
        end
        @(negedge clk); rst_n = 1;
        step();
        n_vec++;
        if (ex_valid !== 1'b1 || ex_op1 !== 64'h1234 || ex_op2 !== 64'h5678 ||
            ex_ctrl !== C_ADD || ex_imm !== 64'hFFFF_FFFF_FFFF_FFF0 || ex_rd !== 5'd4) begin
            n_err++;
            $display("FAIL reset_release_load: valid=%b op1=%h ctrl=%h imm=%h rd=%0d", ex_valid,
                     ex_op1, ex_ctrl, ex_imm, ex_rd);
        end
        #2 rst_n = 0;
        #1;
        n_vec++;
        if (ex_valid !== 1'b0 || ex_op1 !== '0 || ex_ctrl !== '0 || stall !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: valid=%b op1=%h ctrl=%h stall=%b, required zeros",
                     ex_valid, ex_op1, ex_ctrl, stall);
        end
        @(negedge clk); rst_n = 1;
        idle_inputs();
        step();
    endtask

    task automatic test_bypass();
        issue(5'd5, 5'd7, 5'd9, 64'h10, 64'h20, C_ADD);
        wb_regwrite = 1; wb_rd = 5'd5; wb_data = 64'hAB;
        step();
        n_vec++;
        if (ex_op1 !== 64'hAB || ex_op2 !== 64'h20) begin
            n_err++;
            $display("FAIL bypass_op1: op1=%h op2=%h, required AB 20", ex_op1, ex_op2);
        end
        wb_regwrite = 0;
        step();
        n_vec++;
        if (ex_op1 !== 64'h10) begin
            n_err++;
            $display("FAIL bypass_disabled: op1=%h, required 10", ex_op1);
        end
        wb_regwrite = 1; wb_rd = 5'd7; wb_data = 64'hCAFE;
        step();
        n_vec++;
        if (ex_op1 !== 64'h10 || ex_op2 !== 64'hCAFE) begin
            n_err++;
            $display("FAIL bypass_op2: op1=%h op2=%h, required 10 CAFE", ex_op1, ex_op2);
        end
        wb_rd = 5'd6;
        step();
        n_vec++;
        if (ex_op2 !== 64'h20) begin
            n_err++;
            $display("FAIL bypass_index_miss: op2=%h, required 20", ex_op2);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_hazard();
        issue(5'd1, 5'd2, 5'd3, 64'h0, 64'h0, C_LDUR);
        step();
        issue(5'd3, 5'd8, 5'd4, 64'h33, 64'h44, C_ADD);
        #1;
        n_vec++;
        if (stall !== 1'b1) begin
            n_err++;
            $display("FAIL hazard_stall_rn: stall=%b, required 1", stall);
        end
        step();
        n_vec++;
        if (ex_valid !== 1'b0 || ex_ctrl !== '0 || stall !== 1'b0) begin
            n_err++;
            $display("FAIL hazard_bubble: valid=%b ctrl=%h stall=%b, required 0 0 0",
                     ex_valid, ex_ctrl, stall);
        end
        step();
        n_vec++;
        if (ex_valid !== 1'b1 || ex_ctrl !== C_ADD || ex_op1 !== 64'h33 || ex_rd !== 5'd4) begin
            n_err++;
            $display("FAIL hazard_resume: valid=%b ctrl=%h op1=%h rd=%0d", ex_valid, ex_ctrl,
                     ex_op1, ex_rd);
        end
        issue(5'd1, 5'd2, 5'd6, 64'h0, 64'h0, C_LDUR);
        step();
        issue(5'd9, 5'd6, 5'd7, 64'h0, 64'h0, C_SUB);
        id_use_rm = 0;
        #1;
        n_vec++;
        if (stall !== 1'b0) begin
            n_err++;
            $display("FAIL hazard_unused_src: stall=%b, required 0", stall);
        end
        id_use_rm = 1;
        #1;
        n_vec++;
        if (stall !== 1'b1) begin
            n_err++;
            $display("FAIL hazard_stall_rm: stall=%b, required 1", stall);
        end
        flush = 1;
        #1;
        n_vec++;
        if (stall !== 1'b0) begin
            n_err++;
            $display("FAIL hazard_flush_masks: stall=%b, required 0", stall);
        end
        step();
        n_vec++;
        if (ex_valid !== 1'b0 || ex_ctrl !== '0) begin
            n_err++;
            $display("FAIL flush_only: valid=%b ctrl=%h, required 0 0", ex_valid, ex_ctrl);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_flush_hold();
        issue(5'd1, 5'd2, 5'd3, 64'h11, 64'h22, C_ADD);
        step();
        flush = 1; hold = 1;
        #1;
        n_vec++;
        if (stall !== 1'b1) begin
            n_err++;
            $display("FAIL flush_hold_stall: stall=%b, required 1", stall);
        end
        step();
        n_vec++;
        if (ex_valid !== 1'b0 || ex_ctrl !== '0) begin
            n_err++;
            $display("FAIL flush_hold: valid=%b ctrl=%h, required 0 0", ex_valid, ex_ctrl);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_hold();
        issue(5'd10, 5'd11, 5'd12, 64'hAAAA, 64'hBBBB, C_SUB);
        id_imm = 64'h40;
        step();
        hold = 1;
        for (int i = 0; i < 3; i++) begin
            issue(5'(i + 1), 5'(i + 2), 5'(i + 3), 64'(i + 100), 64'(i + 200), C_ADD);
            #1;
            n_vec++;
            if (stall !== 1'b1) begin
                n_err++;
                $display("FAIL hold_stall[%0d]: stall=%b, required 1", i, stall);
            end
            step();
            n_vec++;
            if (ex_valid !== 1'b1 || ex_op1 !== 64'hAAAA || ex_op2 !== 64'hBBBB ||
                ex_ctrl !== C_SUB || ex_imm !== 64'h40 || ex_rn !== 5'd10 ||
                ex_rm !== 5'd11 || ex_rd !== 5'd12) begin
                n_err++;
                $display("FAIL hold_keep[%0d]: valid=%b op1=%h ctrl=%h rn=%0d rd=%0d", i,
                         ex_valid, ex_op1, ex_ctrl, ex_rn, ex_rd);
            end
        end
        hold = 0;
        issue(5'd1, 5'd2, 5'd13, 64'h0, 64'h0, C_LDUR);
        step();
        hold = 1;
        issue(5'd13, 5'd2, 5'd4, 64'h5, 64'h6, C_ADD);
        step();
        n_vec++;
        if (stall !== 1'b1 || ex_valid !== 1'b1 || ex_ctrl !== C_LDUR || ex_rd !== 5'd13) begin
            n_err++;
            $display("FAIL hold_over_hazard: stall=%b valid=%b ctrl=%h rd=%0d", stall,
                     ex_valid, ex_ctrl, ex_rd);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_back_to_back();
        issue(5'd1, 5'd2, 5'd3, 64'h101, 64'h102, C_ADD);
        step();
        issue(5'd4, 5'd5, 5'd6, 64'h201, 64'h202, C_SUB);
        step();
        n_vec++;
        if (ex_valid !== 1'b1 || ex_op1 !== 64'h201 || ex_op2 !== 64'h202 ||
            ex_ctrl !== C_SUB || ex_rd !== 5'd6) begin
            n_err++;
            $display("FAIL b2b_second: op1=%h op2=%h ctrl=%h rd=%0d", ex_op1, ex_op2, ex_ctrl,
                     ex_rd);
        end
        id_valid = 0;
        step();
        n_vec++;
        if (ex_valid !== 1'b0 || ex_ctrl !== '0) begin
            n_err++;
            $display("FAIL b2b_invalid_slot: valid=%b ctrl=%h, required 0 0", ex_valid, ex_ctrl);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_reg31();
        logic [DATA_W-1:0] exp_op2;
        logic              exp_stall;
`ifdef ID_EX_XZR_EN
        exp_op2 = 64'h0;  exp_stall = 1'b0;
`else
        exp_op2 = 64'h77; exp_stall = 1'b1;
`endif
        issue(5'd1, 5'd31, 5'd2, 64'h1, 64'hFF, C_ADD);
        wb_regwrite = 1; wb_rd = 5'd31; wb_data = 64'h77;
        step();
        n_vec++;
        if (ex_op2 !== exp_op2) begin
            n_err++;
            $display("FAIL reg31_operand: op2=%h, required %h", ex_op2, exp_op2);
        end
        wb_regwrite = 0;
        issue(5'd1, 5'd2, 5'd31, 64'h0, 64'h0, C_LDUR);
        step();
        issue(5'd31, 5'd2, 5'd5, 64'h0, 64'h0, C_ADD);
        id_use_rm = 0;
        #1;
        n_vec++;
        if (stall !== exp_stall) begin
            n_err++;
            $display("FAIL reg31_hazard: stall=%b, required %b", stall, exp_stall);
        end
        idle_inputs();
        step();
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_hazard();
        test_flush_hold();
        test_hold();
        test_back_to_back();
        test_reg31();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline register for the ARMv8 pipelined core. Sits directly downstream of the register file: captures both read ports plus decoded control and immediate each cycle, and presents them to the ALU stage. Provides write-through bypass for a same-cycle writeback, load-use hazard detection with bubble insertion, and flush/hold control.

## Interface
- DATA_W, 64, operand/immediate width
- ADDR_W, 5, register index width
- CTRL_W, 10, packed control word width (layout fixed in package)

- clk  in  1  pipeline clock, all state on rising edge
- Reset  in  1  asynchronous, active-low; clears all state
- id_valid  in  1  decode slot holds a real instruction
- id_rn, id_rm, id_rd  in  ADDR_W  source/destination indices (id_rn/id_rm also drive RF ReadReg1/2)
- id_use_rn, id_use_rm  in  1  instruction actually reads that source
- id_rd1, id_rd2  in  DATA_W  RF ReadData1/ReadData2
- id_imm  in  DATA_W  sign-extended immediate
- id_ctrl  in  CTRL_W  {RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, Branch, ALUOp[3:0]}
- wb_regwrite  in  1  writeback write enable (same signals as RF RegWrite)
- wb_rd  in  ADDR_W  writeback index
- wb_data  in  DATA_W  writeback data
- flush  in  1  branch resolved taken; kill decode slot
- hold  in  1  downstream freeze
- ex_valid  out  1  EX slot valid
- ex_op1, ex_op2  out  DATA_W  captured operands
- ex_imm  out  DATA_W
- ex_rn, ex_rm, ex_rd  out  ADDR_W
- ex_ctrl  out  CTRL_W  zero when ex_valid=0
- stall  out  1  combinational: freeze PC and IF/ID this cycle

## Operation
- Bypass: op1 = (wb_regwrite && wb_rd==id_rn) ? wb_data : id_rd1; op2 likewise with id_rm. Needed because the RF write lands on the same edge as capture.
- Hazard: stall = ex_valid && ex_ctrl.MemRead && ex_rd!=0-index-exempt (see Configuration) && ((id_use_rn && ex_rd==id_rn) || (id_use_rm && ex_rd==id_rm)) && id_valid && !flush.
- Per-edge update priority:
  1. flush: ex_valid<=0, ex_ctrl<=0 (other fields don't-care, hold value).
  2. hold: all EX registers keep value; stall forced 1 so upstream also freezes.
  3. stall (hazard): insert bubble, ex_valid<=0, ex_ctrl<=0.
  4. else load: ex_valid<=id_valid; ex_ctrl<=id_valid?id_ctrl:0; operands, imm, indices captured.
- No state machine beyond valid bit; a load-use stall lasts exactly one cycle because the bubble clears the MemRead condition.
- Reset mid-operation: all outputs 0 immediately (asynchronous), stall drops to 0 combinationally.

## Timing
- Reset values: every registered output 0; stall 0.
- Latency: 1 cycle decode to EX outputs; bypass adds no cycle.
- stall is a function of current EX registers and current id_* inputs; valid before the edge it gates.
- Simultaneous flush+hold: flush wins. hold+hazard: hold wins, stall=1.
- wb write with wb_regwrite=0 never bypasses, even if indices match.

## Configuration
- ID_EX_XZR_EN defined: index 31 is XZR. Operands whose source index is 31 capture 0 (no bypass, no RF data); hazard never raised on ex_rd==31.
- Undefined: register 31 is an ordinary register, bypass and hazard apply normally.

## Structure
- Shared package armv8_pipe_pkg: CTRL_W, control-bit index constants (CTRL_REGWRITE … CTRL_ALUOP_LSB), XZR_IDX=31.
- One sub-module: load_use_hazard (combinational stall equation), instantiated once.

## Test plan
- Reset low with id_valid=1 -> all ex_* = 0, stall=0; release -> next edge ex_valid=1, ex_op1=id_rd1.
- id_rn=5, id_rd1=0x10, wb_regwrite=1, wb_rd=5, wb_data=0xAB -> ex_op1=0xAB; same with wb_regwrite=0 -> 0x10.
- EX holds LDUR rd=3 (MemRead=1); decode ADD rn=3 use_rn=1 -> stall=1, next edge ex_valid=0, ex_ctrl=0; following cycle stall=0, ADD loads.
- flush=1 and hold=1 together with id_valid=1 -> ex_valid=0 after edge.
- hold=1 for 3 cycles with changing id inputs -> ex_* unchanged, stall=1 throughout.
- ID_EX_XZR_EN defined: id_rm=31, id_rd2=0xFF, wb_rd=31 wb_data=0x77 -> ex_op2=0; EX load rd=31 + consumer rn=31 -> stall=0.
